// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and defaults for the writeback arbiter.
//   wb_src_e      : writeback source identifier (exe=0, cache=1, mult5=2)
//   wb_payload_t  : one writeback payload (data, addr, instruction, pc)
//   AGE_LIMIT_DEFAULT : default promotion threshold for waiting sources
// -----------------------------------------------------------------------------
package wb_arb_pkg;

    typedef enum logic [1:0] {
        SRC_EXE   = 2'd0,
        SRC_CACHE = 2'd1,
        SRC_MULT5 = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic [31:0] instruction;
        logic [31:0] pc;
    } wb_payload_t;

    localparam int AGE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/wb_age_counter.sv
// -----------------------------------------------------------------------------
// wb_age_counter
// Saturating wait counter for one writeback source. Counts cycles where the
// source is presenting a request but is not granted; clears on a grant or when
// the request goes away. aged_o is high once the count has reached AGE_LIMIT.
// Ports:
//   clk_i   : clock (rising edge)
//   rst_i   : asynchronous active-high reset
//   valid_i : source request
//   ready_i : source grant from the arbiter
//   aged_o  : counter is saturated at AGE_LIMIT
// -----------------------------------------------------------------------------
module wb_age_counter
    import wb_arb_pkg::*;
#(
    parameter int AGE_LIMIT = AGE_LIMIT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    input  logic ready_i,
    output logic aged_o
);

    localparam int CW = $clog2(AGE_LIMIT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (!valid_i || ready_i) begin
            r_count <= '0;
        end else if (r_count != CW'(AGE_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign aged_o = (r_count == CW'(AGE_LIMIT));

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Three-source writeback arbiter in front of a single register-file write
// port. Base priority exe > cache > mult5; the grant is combinational and the
// granted payload is registered onto the write_* outputs one cycle later.
// Writes to x0 are accepted but never strobed.
// Optional feature: define WB_ARBITER_AGING_EN to let a cache or mult5 request
// that has been blocked for AGE_LIMIT cycles outrank exe (cache wins if both).
// Ports:
//   clk_i, rst_i                      : clock, async active-high reset
//   <s>_valid_i / <s>_ready_o         : per-source handshake (exe, cache, mult5)
//   <s>_data_i/addr_i/instruction_i/pc_i : per-source payload
//   wb_stall_i                        : write port unavailable, grant nothing
//   write_enable_o                    : register-file write strobe
//   write_data_o/addr_o/instruction_o/pc_o : registered granted payload
//   write_src_o                       : source of the registered payload
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AGE_LIMIT = AGE_LIMIT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        exe_valid_i,
    output logic        exe_ready_o,
    input  logic [31:0] exe_data_i,
    input  logic [4:0]  exe_addr_i,
    input  logic [31:0] exe_instruction_i,
    input  logic [31:0] exe_pc_i,
    input  logic        cache_valid_i,
    output logic        cache_ready_o,
    input  logic [31:0] cache_data_i,
    input  logic [4:0]  cache_addr_i,
    input  logic [31:0] cache_instruction_i,
    input  logic [31:0] cache_pc_i,
    input  logic        mult5_valid_i,
    output logic        mult5_ready_o,
    input  logic [31:0] mult5_data_i,
    input  logic [4:0]  mult5_addr_i,
    input  logic [31:0] mult5_instruction_i,
    input  logic [31:0] mult5_pc_i,
    input  logic        wb_stall_i,
    output logic        write_enable_o,
    output logic [31:0] write_data_o,
    output logic [4:0]  write_addr_o,
    output logic [31:0] write_instruction_o,
    output logic [31:0] write_pc_o,
    output logic [1:0]  write_src_o
);

    logic        w_cache_aged;
    logic        w_mult5_aged;
    logic [2:0]  w_grant;
    wb_payload_t w_sel_payload;
    wb_src_e     w_sel_src;

    logic        r_write_enable;
    wb_payload_t r_payload;
    wb_src_e     r_src;

`ifdef WB_ARBITER_AGING_EN
    wb_age_counter #(.AGE_LIMIT(AGE_LIMIT)) u_cache_age (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (cache_valid_i),
        .ready_i (w_grant[SRC_CACHE]),
        .aged_o  (w_cache_aged)
    );

    wb_age_counter #(.AGE_LIMIT(AGE_LIMIT)) u_mult5_age (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (mult5_valid_i),
        .ready_i (w_grant[SRC_MULT5]),
        .aged_o  (w_mult5_aged)
    );
`else
    // Strict fixed priority: nothing is ever promoted.
    logic w_unused_age_limit;
    assign w_unused_age_limit = (AGE_LIMIT > 0);
    assign w_cache_aged = 1'b0;
    assign w_mult5_aged = 1'b0;
`endif

    // One-hot grant. Reset and stall suppress every grant so nothing is
    // consumed while the write port cannot take it. The aged flags are gated
    // with valid because a counter still reads saturated for one cycle after
    // its source withdraws.
    always_comb begin
        w_grant = 3'b000;
        if (!rst_i && !wb_stall_i) begin
            if (w_cache_aged && cache_valid_i) begin
                w_grant[SRC_CACHE] = 1'b1;
            end else if (w_mult5_aged && mult5_valid_i) begin
                w_grant[SRC_MULT5] = 1'b1;
            end else if (exe_valid_i) begin
                w_grant[SRC_EXE] = 1'b1;
            end else if (cache_valid_i) begin
                w_grant[SRC_CACHE] = 1'b1;
            end else if (mult5_valid_i) begin
                w_grant[SRC_MULT5] = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_src     = SRC_EXE;
        w_sel_payload = '{exe_data_i, exe_addr_i, exe_instruction_i, exe_pc_i};
        if (w_grant[SRC_CACHE]) begin
            w_sel_src     = SRC_CACHE;
            w_sel_payload = '{cache_data_i, cache_addr_i, cache_instruction_i, cache_pc_i};
        end else if (w_grant[SRC_MULT5]) begin
            w_sel_src     = SRC_MULT5;
            w_sel_payload = '{mult5_data_i, mult5_addr_i, mult5_instruction_i, mult5_pc_i};
        end
    end

    // Payload and source are captured on every transfer (including x0) and
    // held otherwise; only the strobe drops when there is nothing to write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_write_enable <= 1'b0;
            r_payload      <= '0;
            r_src          <= SRC_EXE;
        end else if (|w_grant) begin
            r_write_enable <= (w_sel_payload.addr != 5'd0);
            r_payload      <= w_sel_payload;
            r_src          <= w_sel_src;
        end else begin
            r_write_enable <= 1'b0;
        end
    end

    assign exe_ready_o         = w_grant[SRC_EXE];
    assign cache_ready_o       = w_grant[SRC_CACHE];
    assign mult5_ready_o       = w_grant[SRC_MULT5];
    assign write_enable_o      = r_write_enable;
    assign write_data_o        = r_payload.data;
    assign write_addr_o        = r_payload.addr;
    assign write_instruction_o = r_payload.instruction;
    assign write_pc_o          = r_payload.pc;
    assign write_src_o         = r_src;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed testbench for wb_arbiter. Inputs change 1 time unit after each
// rising edge; outputs are checked in that same settled window.
// Follows WB_ARBITER_AGING_EN for the aging expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        exe_valid, cache_valid, mult5_valid;
    logic        exe_ready, cache_ready, mult5_ready;
    logic [31:0] exe_data, cache_data, mult5_data;
    logic [4:0]  exe_addr, cache_addr, mult5_addr;
    logic [31:0] exe_instr, cache_instr, mult5_instr;
    logic [31:0] exe_pc, cache_pc, mult5_pc;
    logic        stall;
    logic        we;
    logic [31:0] wdata, winstr, wpc;
    logic [4:0]  waddr;
    logic [1:0]  wsrc;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.AGE_LIMIT(4)) u_dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .exe_valid_i         (exe_valid),
        .exe_ready_o         (exe_ready),
        .exe_data_i          (exe_data),
        .exe_addr_i          (exe_addr),
        .exe_instruction_i   (exe_instr),
        .exe_pc_i            (exe_pc),
        .cache_valid_i       (cache_valid),
        .cache_ready_o       (cache_ready),
        .cache_data_i        (cache_data),
        .cache_addr_i        (cache_addr),
        .cache_instruction_i (cache_instr),
        .cache_pc_i          (cache_pc),
        .mult5_valid_i       (mult5_valid),
        .mult5_ready_o       (mult5_ready),
        .mult5_data_i        (mult5_data),
        .mult5_addr_i        (mult5_addr),
        .mult5_instruction_i (mult5_instr),
        .mult5_pc_i          (mult5_pc),
        .wb_stall_i          (stall),
        .write_enable_o      (we),
        .write_data_o        (wdata),
        .write_addr_o        (waddr),
        .write_instruction_o (winstr),
        .write_pc_o          (wpc),
        .write_src_o         (wsrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_readies(input string tag, input logic e, input logic c, input logic m);
        check({tag, ".exe_ready"},   {31'd0, exe_ready},   {31'd0, e});
        check({tag, ".cache_ready"}, {31'd0, cache_ready}, {31'd0, c});
        check({tag, ".mult5_ready"}, {31'd0, mult5_ready}, {31'd0, m});
    endtask

    task automatic check_write(input string tag, input logic e, input logic [1:0] src,
                               input logic [31:0] data, input logic [4:0] addr);
        check({tag, ".we"},   {31'd0, we},    {31'd0, e});
        check({tag, ".src"},  {30'd0, wsrc},  {30'd0, src});
        check({tag, ".data"}, wdata,          data);
        check({tag, ".addr"}, {27'd0, waddr}, {27'd0, addr});
    endtask

    initial begin
        logic aging;
        logic exp_m;
`ifdef WB_ARBITER_AGING_EN
        aging = 1'b1;
`else
        aging = 1'b0;
`endif
        rst = 1'b1; stall = 1'b0;
        exe_valid = 0; cache_valid = 0; mult5_valid = 0;
        exe_data = 0; cache_data = 0; mult5_data = 0;
        exe_addr = 0; cache_addr = 0; mult5_addr = 0;
        exe_instr = 32'h0000_0013; cache_instr = 32'h0000_2003; mult5_instr = 32'h0200_0033;
        exe_pc = 32'h100; cache_pc = 32'h200; mult5_pc = 32'h300;

        // Reset state, with a request already pending (must not be consumed).
        exe_valid = 1; exe_data = 32'hDEADBEEF; exe_addr = 5'd5;
        #2;
        check_readies("reset", 0, 0, 0);
        check_write("reset", 0, 2'd0, 32'd0, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        // First edge after reset: pending exe request transfers.
        check_readies("single", 1, 0, 0);
        tick();
        exe_valid = 0;
        check_write("single", 1, 2'd0, 32'hDEADBEEF, 5'd5);
        check("single.instr", winstr, 32'h0000_0013);
        check("single.pc",    wpc,    32'h100);
        tick();
        check_write("idle_hold", 0, 2'd0, 32'hDEADBEEF, 5'd5);
        $display("txn single-source done");

        // Three-way contention, back-to-back writes.
        exe_valid = 1;   exe_data = 32'h11;   exe_addr = 5'd1;
        cache_valid = 1; cache_data = 32'h22; cache_addr = 5'd2;
        mult5_valid = 1; mult5_data = 32'h33; mult5_addr = 5'd3;
        #1;
        check_readies("cont0", 1, 0, 0);
        tick();
        exe_valid = 0;
        #1;
        check_write("cont1", 1, 2'd0, 32'h11, 5'd1);
        check_readies("cont1", 0, 1, 0);
        tick();
        cache_valid = 0;
        #1;
        check_write("cont2", 1, 2'd1, 32'h22, 5'd2);
        check_readies("cont2", 0, 0, 1);
        tick();
        mult5_valid = 0;
        check_write("cont3", 1, 2'd2, 32'h33, 5'd3);
        check("cont3.pc", wpc, 32'h300);
        tick();
        check("cont_idle.we", {31'd0, we}, 32'd0);
        $display("txn contention done");

        // Stall for three cycles with cache waiting.
        stall = 1; cache_valid = 1; cache_data = 32'h77; cache_addr = 5'd7;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_readies("stall", 0, 0, 0);
            tick();
            check("stall.we", {31'd0, we}, 32'd0);
        end
        stall = 0;
        #1;
        check_readies("unstall", 0, 1, 0);
        tick();
        cache_valid = 0;
        check_write("unstall", 1, 2'd1, 32'h77, 5'd7);
        tick();
        $display("txn stall done");

        // x0 discard.
        mult5_valid = 1; mult5_data = 32'h55; mult5_addr = 5'd0;
        #1;
        check_readies("x0", 0, 0, 1);
        tick();
        mult5_valid = 0;
        check_write("x0", 0, 2'd2, 32'h55, 5'd0);
        tick();
        $display("txn x0 discard done");

        // Aging: exe continuously valid, mult5 valid from cycle 0.
        exe_valid = 1;   exe_data = 32'h99;   exe_addr = 5'd9;
        mult5_valid = 1; mult5_data = 32'hAA; mult5_addr = 5'd10;
        for (int k = 0; k < 8; k++) begin
            exp_m = aging && (k == 4);
            #1;
            check_readies($sformatf("age%0d", k), !exp_m, 0, exp_m);
            tick();
            if (exp_m) begin
                mult5_valid = 0;
                check_write("age_grant", 1, 2'd2, 32'hAA, 5'd10);
            end else begin
                check(($sformatf("age%0d.src", k)), {30'd0, wsrc}, 32'd0);
            end
        end
        exe_valid = 0; mult5_valid = 0;
        tick();
        $display("txn aging done");

        // Reset mid-operation: cache blocked behind exe for two cycles.
        exe_valid = 1; exe_data = 32'h44; exe_addr = 5'd4;
        cache_valid = 1; cache_data = 32'h66; cache_addr = 5'd6;
        tick();
        tick();
        check("pre_rst.we", {31'd0, we}, 32'd1);
        #2;
        rst = 1;
        #1;
        check_readies("mid_rst", 0, 0, 0);
        check_write("mid_rst", 0, 2'd0, 32'd0, 5'd0);
        exe_valid = 0;
        @(negedge clk);
        rst = 0;
        #1;
        check_readies("post_rst", 0, 1, 0);
        tick();
        cache_valid = 0;
        check_write("post_rst", 1, 2'd1, 32'h66, 5'd6);
        // Counter cleared: cache waits behind exe again without early promotion.
        exe_valid = 1; cache_valid = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_readies($sformatf("post_rst_age%0d", k), 1, 0, 0);
            tick();
        end
        exe_valid = 0; cache_valid = 0;
        tick();
        $display("txn reset mid-operation done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
